bus_xfer_dec: RTL and testbench

BUS_XFER_DEC -- requirements
Module: bus_xfer_dec

---
 rtl/bus_xfer_dec.sv | 123 ++++++++++++
 tb/tb_bus_xfer_dec.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_dec.sv
// Register-transfer decoder: turns a (source, destination) request into a timed
// one-hot bus-drive strobe followed by a one-cycle register-load strobe.
module bus_xfer_dec #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clock_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [4:0]  src_sel_i,
  input  logic [4:0]  dst_sel_i,
  output logic [23:0] out_en_o,
  output logic [23:0] in_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned CodeW    = 5;
  localparam int unsigned NumCodes = 24;
  localparam int unsigned CntW     = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    LOAD  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CodeW-1:0]    src_q, src_d;
  logic [CodeW-1:0]    dst_q, dst_d;
  logic [NumCodes-1:0] out_en_d, in_en_d;
  logic                busy_d, done_d, err_d;
  logic                reject_c;

  assign reject_c = (src_sel_i > CodeW'(NumCodes - 1)) ||
                    (dst_sel_i > CodeW'(NumCodes - 1)) ||
                    (src_sel_i == dst_sel_i);

  // State, captured codes, settle counter and registered outputs.
  always_ff @(posedge clock_i or negedge clear_i) begin
    if (!clear_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      out_en_o <= '0;
      in_en_o  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      out_en_o <= out_en_d;
      in_en_o  <= in_en_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      err_o    <= err_d;
    end
  end

  // Next state. DONE/ERR fall back to IDLE on the same edge that IDLE samples
  // start, so a held request restarts every SETTLE+2 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        state_d = IDLE;
        if (start_i) begin
          src_d = src_sel_i;
          dst_d = dst_sel_i;
          if (reject_c) begin
            state_d = ERR;
          end else begin
            state_d = DRIVE;
            cnt_d   = CntW'(SETTLE - 1);
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      LOAD:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so strobes appear on the entry edge.
  always_comb begin
    out_en_d = '0;
    in_en_d  = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_d)
      DRIVE: begin
        out_en_d = NumCodes'(1) << src_d;
        busy_d   = 1'b1;
      end
      LOAD: begin
        out_en_d = NumCodes'(1) << src_d;
        in_en_d  = NumCodes'(1) << dst_d;
        busy_d   = 1'b1;
      end
      DONE:    done_d = 1'b1;
      ERR:     err_d  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_xfer_dec.sv
// Bench for bus_xfer_dec: two instances (SETTLE=1 and SETTLE=3) checked every
// cycle against a schedule-queue model, plus hand-computed literal expectations.
module tb_bus_xfer_dec;

  typedef struct packed {
    logic [23:0] oe;
    logic [23:0] ie;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic        clk_i   = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  src_i   = '0;
  logic [4:0]  dst_i   = '0;
  logic [23:0] oe   [2];
  logic [23:0] ie   [2];
  logic        busy [2];
  logic        done [2];
  logic        err  [2];

  exp_t mq  [2][$];
  exp_t cur [2];
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  bus_xfer_dec #(.SETTLE(1)) u0 (
    .clock_i(clk_i), .clear_i(clear_i), .start_i(start_i),
    .src_sel_i(src_i), .dst_sel_i(dst_i),
    .out_en_o(oe[0]), .in_en_o(ie[0]), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
  );

  bus_xfer_dec #(.SETTLE(3)) u1 (
    .clock_i(clk_i), .clear_i(clear_i), .start_i(start_i),
    .src_sel_i(src_i), .dst_sel_i(dst_i),
    .out_en_o(oe[1]), .in_en_o(ie[1]), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
  );

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] t=%0t actual=%h required=%h", nm, inst, $time, act, exp);
    end
  endtask

  // Queue the full per-cycle output schedule of one accepted request.
  task automatic push_request(input int i);
    exp_t e;
    if (src_i > 5'd23 || dst_i > 5'd23 || src_i == dst_i) begin
      e = '0; e.err = 1'b1;
      mq[i].push_back(e);
    end else begin
      for (int c = 0; c < settle_of(i); c++) begin
        e = '0; e.oe = 24'(1) << src_i; e.busy = 1'b1;
        mq[i].push_back(e);
      end
      e = '0; e.oe = 24'(1) << src_i; e.ie = 24'(1) << dst_i; e.busy = 1'b1;
      mq[i].push_back(e);
      e = '0; e.done = 1'b1;
      mq[i].push_back(e);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check("out_en", i, 32'(oe[i]),   32'(cur[i].oe));
      check("in_en",  i, 32'(ie[i]),   32'(cur[i].ie));
      check("busy",   i, 32'(busy[i]), 32'(cur[i].busy));
      check("done",   i, 32'(done[i]), 32'(cur[i].done));
      check("err",    i, 32'(err[i]),  32'(cur[i].err));
    end
  endtask

  // One clock: model consumes this edge's inputs, then outputs are compared.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (clear_i) begin
        if (mq[i].size() == 0 && start_i) push_request(i);
        cur[i] = (mq[i].size() != 0) ? mq[i].pop_front() : '0;
      end else begin
        cur[i] = '0;
      end
    end
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  // Asynchronous clear pulse between edges; called 1 time unit after an edge.
  task automatic abort_pulse();
    #2;
    clear_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      cur[i] = '0;
    end
    #1;
    compare_all();
    #2;
    clear_i = 1'b1;
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    for (int c = 0; c < n; c++) step();
  endtask

  int ndone0, ndone1;

  initial begin
    for (int i = 0; i < 2; i++) cur[i] = '0;
    for (int c = 0; c < 3; c++) step();
    clear_i = 1'b1;
    idle(2);
    check("reset_out_en", 1, 32'(oe[1]), 32'h0);
    check("reset_busy",   1, 32'(busy[1]), 32'h0);

    // PC -> MDR on SETTLE=1
    start_i = 1'b1; src_i = 5'd20; dst_i = 5'd21;
    step();
    start_i = 1'b0;
    check("pc_k_oe", 0, 32'(oe[0]), 32'h100000);
    check("pc_k_ie", 0, 32'(ie[0]), 32'h0);
    check("pc_k_busy", 0, 32'(busy[0]), 32'h1);
    step();
    check("pc_k1_oe", 0, 32'(oe[0]), 32'h100000);
    check("pc_k1_ie", 0, 32'(ie[0]), 32'h200000);
    step();
    check("pc_k2_done", 0, 32'(done[0]), 32'h1);
    check("pc_k2_oe",   0, 32'(oe[0]), 32'h0);
    idle(6);

    // R4 -> HI on SETTLE=3
    start_i = 1'b1; src_i = 5'd4; dst_i = 5'd16;
    for (int c = 1; c <= 4; c++) begin
      step();
      start_i = 1'b0;
      check("r4_oe",   1, 32'(oe[1]), 32'h10);
      check("r4_ie",   1, 32'(ie[1]), (c == 4) ? 32'h10000 : 32'h0);
      check("r4_busy", 1, 32'(busy[1]), 32'h1);
    end
    step();
    check("r4_done", 1, 32'(done[1]), 32'h1);
    check("r4_busy_end", 1, 32'(busy[1]), 32'h0);
    idle(6);

    // Rejections
    for (int r = 0; r < 3; r++) begin
      start_i = 1'b1;
      src_i = (r == 0) ? 5'd24 : ((r == 1) ? 5'd3 : 5'd7);
      dst_i = (r == 0) ? 5'd2  : ((r == 1) ? 5'd31 : 5'd7);
      step();
      start_i = 1'b0;
      check("rej_err",  1, 32'(err[1]), 32'h1);
      check("rej_oe",   1, 32'(oe[1]), 32'h0);
      check("rej_busy", 1, 32'(busy[1]), 32'h0);
      step();
      check("rej_err_off", 1, 32'(err[1]), 32'h0);
    end
    idle(2);

    // Inputs disturbed mid-transfer
    start_i = 1'b1; src_i = 5'd2; dst_i = 5'd3;
    step();
    for (int c = 0; c < 3; c++) begin
      start_i = ~start_i; src_i = 5'(c + 8); dst_i = 5'(c + 12);
      step();
    end
    check("dist_ie", 1, 32'(ie[1]), 32'h8);
    idle(6);

    // Abort in DRIVE
    start_i = 1'b1; src_i = 5'd9; dst_i = 5'd10;
    step();
    start_i = 1'b0;
    abort_pulse();
    check("abort_oe", 1, 32'(oe[1]), 32'h0);
    idle(6);
    start_i = 1'b1; src_i = 5'd5; dst_i = 5'd6;
    step();
    start_i = 1'b0;
    check("after_abort_oe", 1, 32'(oe[1]), 32'h20);
    idle(6);

    // Held start: back-to-back transfers
    start_i = 1'b1; src_i = 5'd0; dst_i = 5'd1;
    ndone0 = 0; ndone1 = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      ndone0 += int'(done[0]);
      ndone1 += int'(done[1]);
    end
    check("held_dones", 0, 32'(ndone0), 32'd6);
    check("held_dones", 1, 32'(ndone1), 32'd4);
    idle(6);

    // Randomised traffic with occasional asynchronous clears
    for (int n = 0; n < 600; n++) begin
      start_i = ($urandom_range(0, 2) != 0);
      src_i = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      dst_i = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      if ($urandom_range(0, 79) == 0) abort_pulse();
      step();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
